// File: rtl/max7219_spi_receiver.sv
// Receive-side model of a MAX7219: synchronizes an SPI mode-0 stream, decodes
// 16-bit frames into the register file and flags frames shorter than 16 bits.
`timescale 1ns/1ps
module max7219_spi_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic       dout,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    output logic [4:0] bit_count,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       display_test
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr;
    logic       sclk_d, cs_d;
    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic       start_frame, shift_en, dout_en, end_frame;
    logic [15:0] shreg;
    logic [7:0]  digit [8];
    logic [2:0]  digit_idx;

    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign digit_idx = shreg[10:8] - 3'd1;
    assign rd_data   = digit[rd_row];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sr <= '0;
            mosi_sr <= '0;
            cs_sr   <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs};
            sclk_d  <= sclk_s;
            cs_d    <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_IDLE;
        else        state <= state_nxt;
    end

    // A cs rise ends the frame and suppresses any sclk edge seen in the same cycle.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        dout_en     = 1'b0;
        end_frame   = 1'b0;
        case (state)
            WAIT_IDLE: if (cs_s) state_nxt = IDLE;
            IDLE: begin
                if (cs_fall) begin
                    state_nxt   = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    end_frame = 1'b1;
                end else begin
                    shift_en = sclk_rise;
                    dout_en  = sclk_fall;
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg        <= '0;
            bit_count    <= '0;
            dout         <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) digit[i] <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (start_frame) bit_count <= '0;
            if (shift_en) begin
                shreg <= {shreg[14:0], mosi_s};
                if (bit_count != 5'd31) bit_count <= bit_count + 5'd1;
            end
            if (dout_en) dout <= shreg[15];
            if (end_frame) begin
                if (bit_count >= 5'd16) begin
                    frame_valid <= 1'b1;
                    frame_addr  <= shreg[11:8];
                    frame_data  <= shreg[7:0];
                    case (shreg[11:8])
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: digit[digit_idx] <= shreg[7:0];
                        4'h9: decode_mode  <= shreg[7:0];
                        4'hA: intensity    <= shreg[3:0];
                        4'hB: scan_limit   <= shreg[2:0];
                        4'hC: shutdown_n   <= shreg[0];
                        4'hF: display_test <= shreg[0];
                        default: ;
                    endcase
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// Self-checking bench for max7219_spi_receiver: directed frames plus random
// frames compared against a frame-level register model.
`timescale 1ns/1ps
module tb_max7219_spi_receiver;

    logic       clk, reset, sclk, mosi, cs;
    logic       dout, frame_valid, frame_err;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic [4:0] bit_count;
    logic [2:0] rd_row;
    logic [7:0] rd_data, decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n, display_test;

    max7219_spi_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs),
        .dout(dout), .frame_valid(frame_valid), .frame_err(frame_err),
        .frame_addr(frame_addr), .frame_data(frame_data), .bit_count(bit_count),
        .rd_row(rd_row), .rd_data(rd_data), .decode_mode(decode_mode),
        .intensity(intensity), .scan_limit(scan_limit),
        .shutdown_n(shutdown_n), .display_test(display_test)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int seen_valid = 0, seen_err = 0, exp_valid = 0, exp_err = 0;

    // Reference model: register file contents implied by the frames sent so far.
    logic [7:0] m_digit [8];
    logic [7:0] m_decode, m_data;
    logic [3:0] m_int, m_addr;
    logic [2:0] m_scan;
    logic       m_shut, m_test;
    int         m_bitcnt;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) seen_valid++;
        if (frame_err === 1'b1) seen_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = '0;
        m_decode = '0; m_data = '0; m_int = '0; m_addr = '0;
        m_scan = '0; m_shut = 1'b0; m_test = 1'b0; m_bitcnt = 0;
    endtask

    task automatic model_frame(input logic [63:0] bits, input int n);
        logic [15:0] w;
        m_bitcnt = (n > 31) ? 31 : n;
        if (n < 16) begin
            exp_err++;
            return;
        end
        exp_valid++;
        w = bits[15:0];
        m_addr = w[11:8];
        m_data = w[7:0];
        if (m_addr >= 4'd1 && m_addr <= 4'd8) m_digit[m_addr - 4'd1] = m_data;
        else if (m_addr == 4'h9) m_decode = m_data;
        else if (m_addr == 4'hA) m_int = m_data[3:0];
        else if (m_addr == 4'hB) m_scan = m_data[2:0];
        else if (m_addr == 4'hC) m_shut = m_data[0];
        else if (m_addr == 4'hF) m_test = m_data[0];
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        mosi = b;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
        wait_clk(4);
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            rd_row = 3'(r);
            #1;
            chk({tag, "_digit"}, rd_data, m_digit[r]);
        end
        chk({tag, "_decode"}, decode_mode, m_decode);
        chk({tag, "_intensity"}, intensity, m_int);
        chk({tag, "_scan"}, scan_limit, m_scan);
        chk({tag, "_shutdown"}, shutdown_n, m_shut);
        chk({tag, "_test"}, display_test, m_test);
        chk({tag, "_addr"}, frame_addr, m_addr);
        chk({tag, "_data"}, frame_data, m_data);
        chk({tag, "_bitcnt"}, bit_count, m_bitcnt);
    endtask

    // Sends the low n bits of 'bits', MSB first, and checks dout and pulse timing.
    task automatic send_frame(input string tag, input logic [63:0] bits, input int n);
        logic ev, ee;
        cs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) begin
            shift_bit(bits[n-1-i]);
            if (i >= 15) chk({tag, "_dout"}, dout, bits[n+14-i]);
        end
        cs = 1'b1;
        ev = (n >= 16);
        ee = (n < 16);
        model_frame(bits, n);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk({tag, "_valid"}, frame_valid, (k == 3) ? ev : 1'b0);
            chk({tag, "_err"}, frame_err, (k == 3) ? ee : 1'b0);
        end
        check_regs(tag);
    endtask

    initial begin
        logic [63:0] rb;
        int          rn;
        reset = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rd_row = '0;
        model_reset();
        wait_clk(3);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_dout", dout, 1'b0);
        check_regs("rst");
        reset = 1'b1;
        wait_clk(6);

        send_frame("shutdown", 64'h0C01, 16);
        send_frame("digit1", 64'h02A5, 16);
        send_frame("disptest", 64'h0F01, 16);
        send_frame("noop_d", 64'h0D33, 16);
        send_frame("short_a", 64'h0C, 8);
        send_frame("short_b", 64'h01, 8);
        send_frame("long24", 64'hFF0A07, 24);
        send_frame("sat35", 64'h5_5A55_0901, 35);

        // Reset in the middle of a frame: the remaining traffic must be ignored.
        cs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_shut", shutdown_n, 1'b0);
        chk("midrst_bitcnt", bit_count, 5'd0);
        chk("midrst_addr", frame_addr, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 11; i++) shift_bit(1'b0);
        cs = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_valid", frame_valid, 1'b0);
            chk("midrst_err", frame_err, 1'b0);
        end
        check_regs("midrst");
        send_frame("scan5", 64'h0B05, 16);

        for (int f = 0; f < 16; f++) begin
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rn = int'($urandom_range(1, 15));
                1: rn = int'($urandom_range(17, 40));
                default: rn = 16;
            endcase
            send_frame("rand", rb, rn);
        end

        wait_clk(4);
        chk("total_valid", 32'(seen_valid), 32'(exp_valid));
        chk("total_err", 32'(seen_err), 32'(exp_err));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
